// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state encodings, op decoder and XLEN legality check for muldiv
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic is_div;
        logic want_hi;
        logic want_rem;
        logic a_signed;
        logic b_signed;
    } op_dec_t;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    // MUL low half is sign-agnostic, so it runs as unsigned
    function automatic op_dec_t decode_op(input op_e op);
        op_dec_t d;
        d = '0;
        case (op)
            OP_MUL:    d = '{is_div: 1'b0, want_hi: 1'b0, want_rem: 1'b0, a_signed: 1'b0, b_signed: 1'b0};
            OP_MULH:   d = '{is_div: 1'b0, want_hi: 1'b1, want_rem: 1'b0, a_signed: 1'b1, b_signed: 1'b1};
            OP_MULHSU: d = '{is_div: 1'b0, want_hi: 1'b1, want_rem: 1'b0, a_signed: 1'b1, b_signed: 1'b0};
            OP_MULHU:  d = '{is_div: 1'b0, want_hi: 1'b1, want_rem: 1'b0, a_signed: 1'b0, b_signed: 1'b0};
            OP_DIV:    d = '{is_div: 1'b1, want_hi: 1'b0, want_rem: 1'b0, a_signed: 1'b1, b_signed: 1'b1};
            OP_DIVU:   d = '{is_div: 1'b1, want_hi: 1'b0, want_rem: 1'b0, a_signed: 1'b0, b_signed: 1'b0};
            OP_REM:    d = '{is_div: 1'b1, want_hi: 1'b0, want_rem: 1'b1, a_signed: 1'b1, b_signed: 1'b1};
            OP_REMU:   d = '{is_div: 1'b1, want_hi: 1'b0, want_rem: 1'b1, a_signed: 1'b0, b_signed: 1'b0};
            default:   d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - conditional two's-complement negation for operand magnitude and result sign
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] fixed
);

    assign fixed = negate ? ((~value) + {{(W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative RV M-extension multiply/divide unit; MULDIV_FAST_MUL_EN makes multiplies single-cycle
module muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("muldiv: XLEN must be 32 or 64");
    end

    state_e            state_q, state_d;
    op_dec_t           dec;
    logic              accept;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic              div_zero, div_ovf, div_special;
    logic [XLEN-1:0]   special_res;
    logic              fast_take;
    logic [XLEN-1:0]   fast_res;

    // hi/lo hold partial product (mul) or remainder/quotient (div); dvs holds multiplicand or divisor
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_div_q, is_div_d, want_hi_q, want_hi_d, want_rem_q, want_rem_d;
    logic              neg_main_q, neg_main_d, neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic              div_ge, last_step;
    logic [XLEN-1:0]   hi_step, lo_step;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, iter_res;

    assign dec    = decode_op(op_e'(op));
    assign accept = in_valid & in_ready & ~kill;
    assign a_neg  = dec.a_signed & a[XLEN-1];
    assign b_neg  = dec.b_signed & b[XLEN-1];

    muldiv_signfix #(.W(XLEN)) u_abs_a (.value(a), .negate(a_neg), .fixed(a_abs));
    muldiv_signfix #(.W(XLEN)) u_abs_b (.value(b), .negate(b_neg), .fixed(b_abs));

    // Division corner cases resolve at accept time and bypass the iteration
    assign div_zero    = dec.is_div & (b == '0);
    assign div_ovf     = dec.is_div & dec.a_signed & (a == MIN_NEG) & (b == '1);
    assign div_special = div_zero | div_ovf;
    assign special_res = div_zero ? (dec.want_rem ? a : '1) : (dec.want_rem ? '0 : a);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    assign fast_a    = {{XLEN{a_neg}}, a};
    assign fast_b    = {{XLEN{b_neg}}, b};
    assign fast_prod = fast_a * fast_b;
    assign fast_take = ~dec.is_div;
    assign fast_res  = dec.want_hi ? fast_prod[2*XLEN-1:XLEN] : fast_prod[XLEN-1:0];
`else
    assign fast_take = 1'b0;
    assign fast_res  = '0;
`endif

    // One shift-add or restoring-subtract step per BUSY cycle; the borrow bit decides the quotient bit
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : {(XLEN+1){1'b0}});
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, dvs_q};
    assign div_ge    = ~div_diff[XLEN];
    assign hi_step   = is_div_q ? (div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]) : mul_sum[XLEN:1];
    assign lo_step   = is_div_q ? {lo_q[XLEN-2:0], div_ge} : {mul_sum[0], lo_q[XLEN-1:1]};
    assign last_step = (cnt_q == CNT_W'(XLEN-1));

    muldiv_signfix #(.W(2*XLEN)) u_fix_prod (.value({hi_step, lo_step}), .negate(neg_main_q), .fixed(prod_fix));
    muldiv_signfix #(.W(XLEN))   u_fix_quo  (.value(lo_step), .negate(neg_main_q), .fixed(quo_fix));
    muldiv_signfix #(.W(XLEN))   u_fix_rem  (.value(hi_step), .negate(neg_rem_q),  .fixed(rem_fix));

    assign iter_res = is_div_q ? (want_rem_q ? rem_fix : quo_fix)
                               : (want_hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0]);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: kill wins from any state; corner cases and fast multiplies skip BUSY
    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (in_valid) state_d = (div_special | fast_take) ? ST_DONE : ST_BUSY;
                ST_BUSY: if (last_step) state_d = ST_DONE;
                ST_DONE: if (out_ready) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    assign result = result_q;

    // Datapath next values: load on accept, step while BUSY, result written only when entering DONE
    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        dvs_d      = dvs_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        want_hi_d  = want_hi_q;
        want_rem_d = want_rem_q;
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        if (accept) begin
            hi_d       = '0;
            lo_d       = a_abs;
            dvs_d      = b_abs;
            cnt_d      = '0;
            is_div_d   = dec.is_div;
            want_hi_d  = dec.want_hi;
            want_rem_d = dec.want_rem;
            neg_main_d = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
            if (div_special)    result_d = special_res;
            else if (fast_take) result_d = fast_res;
        end else if ((state_q == ST_BUSY) && !kill) begin
            hi_d  = hi_step;
            lo_d  = lo_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_step) result_d = iter_res;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q       <= '0;
            lo_q       <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            want_hi_q  <= 1'b0;
            want_rem_q <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
        end else begin
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dvs_q      <= dvs_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            want_hi_q  <= want_hi_d;
            want_rem_q <= want_rem_d;
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv.sv
// tb/tb_muldiv.sv - randomized and directed self-checking bench for muldiv (XLEN=32)
module tb_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          expect_valid = 1'b0;
    logic [31:0] exp_res = '0;

    muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .kill(kill), .out_valid(out_valid),
        .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic following the RV M-extension rules
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int          sx32, sy32;
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        sx32 = x; sy32 = y;
        sx = sx32; sy = sy32;
        ux = longint'({32'b0, x}); uy = longint'({32'b0, y});
        case (o)
            3'd0: begin p = ux * uy; return p[31:0];  end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return x;
                p = sx / sy; return p[31:0];
            end
            3'd5: begin
                if (y == 0) return 32'hFFFFFFFF;
                p = ux / uy; return p[31:0];
            end
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
                p = sx % sy; return p[31:0];
            end
            default: begin
                if (y == 0) return x;
                p = ux % uy; return p[31:0];
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && y == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!o[2]) return 1;
`endif
        return 33;
    endfunction

    // Compare process: every cycle a result is offered it must be expected, match the model and block new requests
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            check("valid_expected", 64'(expect_valid), 64'd1);
            if (expect_valid) check("result", result, exp_res);
            check("in_ready_in_done", in_ready, 1'b0);
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int hold, input bit use_lit, input logic [31:0] lit);
        int lat;
        @(negedge clk);
        check("idle_ready", in_ready, 1'b1);
        op = o; a = x; b = y; in_valid = 1'b1;
        exp_res = model(o, x, y);
        expect_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom(); b = $urandom();
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen", out_valid, 1'b1);
        check("latency", 64'(lat), 64'(exp_latency(o, x, y)));
        if (use_lit) check("literal", result, lit);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("held_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_ready", in_ready, 1'b1);
        check("release_valid", out_valid, 1'b0);
        out_ready = 1'b0;
        expect_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; kill = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_result", result, 32'h0);
        rst_n = 1'b1;

        run_op(3'd1, 32'h80000000, 32'h80000000, 0, 1'b1, 32'h40000000);
        run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b1, 32'h00000001);
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b1, 32'hFFFFFFFF);
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b1, 32'hFFFFFFFE);
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b1, 32'h00000000);
        run_op(3'd4, 32'hFFFFFFF9, 32'h2,        0, 1'b1, 32'hFFFFFFFD);
        run_op(3'd6, 32'hFFFFFFF9, 32'h2,        0, 1'b1, 32'hFFFFFFFF);
        run_op(3'd5, 32'hFFFFFFF9, 32'h2,        0, 1'b1, 32'h7FFFFFFC);
        run_op(3'd7, 32'hFFFFFFF9, 32'h2,        0, 1'b1, 32'h00000001);
        run_op(3'd4, 32'h7,        32'h0,        0, 1'b1, 32'hFFFFFFFF);
        run_op(3'd6, 32'h7,        32'h0,        0, 1'b1, 32'h00000007);
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 0, 1'b1, 32'h80000000);
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 0, 1'b1, 32'h00000000);
        // backpressure: five cycles of out_ready low
        run_op(3'd4, 32'd1000,     32'd7,        5, 1'b1, 32'd142);

        // kill offered alongside a request in IDLE must not accept it
        @(negedge clk);
        op = 3'd5; a = 32'd100; b = 32'd3; in_valid = 1'b1; kill = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; kill = 1'b0;
        check("kill_no_accept", in_ready, 1'b1);

        // kill ten cycles into BUSY
        @(negedge clk);
        op = 3'd4; a = 32'd12345; b = 32'd17; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_not_ready", in_ready, 1'b0);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_idle_ready", in_ready, 1'b1);
        check("kill_no_valid", out_valid, 1'b0);
        repeat (40) @(negedge clk);

        // asynchronous reset pulse twenty cycles into BUSY
        op = 3'd0; a = 32'hDEADBEEF; b = 32'h1234; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("rst_still_idle", in_ready, 1'b1);
        run_op(3'd4, 32'hFFFFFF9C, 32'd7, 0, 1'b1, 32'hFFFFFFF2);

        for (int i = 0; i < 200; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            if ($urandom_range(0, 19) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            run_op(ro, ra, rb, $urandom_range(0, 2), 1'b0, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width; legal values are 32 and 64.
REQ-002 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request offered.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port op  input  3  RV M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have ports a, b  input  XLEN  rs1 and rs2 operands.
REQ-008 SHALL have port kill  input  1  abandon any in-flight operation.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  XLEN  operation result.

Function
REQ-012 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-013 SHALL accept a request on an edge where in_valid & in_ready & !kill, and latch op, a and b.
REQ-014 SHALL produce MUL as the low XLEN bits and MULH/MULHSU/MULHU as the high XLEN bits of the 2*XLEN product (signed*signed, signed*unsigned, unsigned*unsigned).
REQ-015 SHALL produce DIV/REM with the quotient truncated toward zero and the remainder taking the sign of the dividend; DIVU/REMU unsigned.
REQ-016 SHALL compute iteratively, one bit per cycle: BUSY lasts exactly XLEN cycles, so out_valid rises XLEN+1 edges after the accept edge.
REQ-017 SHALL handle division by zero with quotient all-ones and remainder a, skipping BUSY (out_valid 1 edge after accept).
REQ-018 SHALL handle signed overflow (a = -2^(XLEN-1), b = -1, DIV/REM) with quotient a and remainder 0, skipping BUSY.
REQ-019 SHALL hold result stable while out_valid & !out_ready, and return to IDLE on the edge where out_valid & out_ready.
REQ-020 SHALL NOT accept a new request in DONE; back-to-back throughput is one request per (latency + 1) cycles.
REQ-021 SHALL on kill force IDLE on the next edge from any state, drop any pending result, and accept no request that cycle.
REQ-022 SHALL keep result unchanged when out_valid is low (no glitching through intermediate values is required, but the value is don't-care to consumers).

Reset
REQ-023 SHALL on rst_n low immediately force state IDLE, out_valid 0, in_ready 1 and result 0, including mid-operation.
REQ-024 SHALL resume normal acceptance on the first edge after rst_n deasserts.

Configuration
REQ-025 SHALL support macro MULDIV_FAST_MUL_EN: when defined, MUL/MULH/MULHSU/MULHU complete combinationally with out_valid 1 edge after accept (no BUSY); division is unchanged.
REQ-026 SHALL, without MULDIV_FAST_MUL_EN, use the iterative shift-add multiplier of REQ-016 (no hardware multiplier inferred).

Structure
REQ-027 SHALL place the op encoding enum, the FSM state enum and the XLEN legality check in package muldiv_pkg, shared with the decoder.
REQ-028 SHALL factor operand sign handling (absolute value in, sign correction out) into sub-module muldiv_signfix, instantiated for operands and for results.

Verification (XLEN=32)
REQ-029 SHALL cover MULH 0x80000000 * 0x80000000 -> 0x40000000, out_valid exactly 33 edges after accept (1 with MULDIV_FAST_MUL_EN).
REQ-030 SHALL cover a=0xFFFFFFFF, b=0xFFFFFFFF: MUL -> 0x00000001, MULHSU -> 0xFFFFFFFF, MULHU -> 0xFFFFFFFE, MULH -> 0x00000000.
REQ-031 SHALL cover DIV/REM -7 / 2 -> 0xFFFFFFFD / 0xFFFFFFFF, and DIVU/REMU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC / 0x00000001.
REQ-032 SHALL cover DIV 7 / 0 -> 0xFFFFFFFF, REM 7 / 0 -> 0x00000007, and DIV/REM 0x80000000 / 0xFFFFFFFF -> 0x80000000 / 0x00000000, each valid 1 edge after accept.
REQ-033 SHALL cover backpressure: out_ready low for 5 cycles after out_valid -> result and out_valid stable, in_ready 0; then out_ready high -> IDLE next edge.
REQ-034 SHALL cover kill at BUSY cycle 10 and rst_n pulse at BUSY cycle 20 -> IDLE, in_ready 1, out_valid never asserted; next request completes correctly.
